// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings and op-select width.
// Optional result flags are enabled by defining LOGIC_PIPE_FLAGS_EN.
package logic_unit_pipe_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        LU_OP_AND   = 3'b000,
        LU_OP_OR    = 3'b001,
        LU_OP_XOR   = 3'b010,
        LU_OP_NOR   = 3'b011,
        LU_OP_NAND  = 3'b100,
        LU_OP_XNOR  = 3'b101,
        LU_OP_ANDN  = 3'b110,
        LU_OP_PASSA = 3'b111
    } lu_op_e;

    // Extra bits stored alongside each result when the flag outputs are built in.
`ifdef LOGIC_PIPE_FLAGS_EN
    localparam int LU_FLAG_W = 2;
`else
    localparam int LU_FLAG_W = 0;
`endif

endpackage

// File: rtl/logic_unit_pipe_slot.sv
// One register slot of the logic unit pipeline: a valid bit plus a data word.
// Holds its beat while downstream stalls and accepts a new beat whenever it is empty or draining.
module logic_pipe_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         prev_valid,
    input  logic [W-1:0] prev_data,
    input  logic         next_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ready
);

    // An empty slot takes a beat even when everything after it is stalled.
    assign ready = !valid || next_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with STAGES register slots and valid/ready on both sides.
// Define LOGIC_PIPE_FLAGS_EN to add out_zero/out_par, computed at accept and carried with the result.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y
`ifdef LOGIC_PIPE_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_par
`endif
);

    localparam int DW = WIDTH + LU_FLAG_W;

    function automatic logic [WIDTH-1:0] eval_op(
        input logic [LU_OP_W-1:0] op,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b
    );
        logic [WIDTH-1:0] y;
        y = '0;
        case (lu_op_e'(op))
            LU_OP_AND:   y = a & b;
            LU_OP_OR:    y = a | b;
            LU_OP_XOR:   y = a ^ b;
            LU_OP_NOR:   y = ~(a | b);
            LU_OP_NAND:  y = ~(a & b);
            LU_OP_XNOR:  y = ~(a ^ b);
            LU_OP_ANDN:  y = a & ~b;
            LU_OP_PASSA: y = a;
        endcase
        return y;
    endfunction

    logic [WIDTH-1:0] result;
    logic [DW-1:0]    entry;

    assign result = eval_op(in_op, in_a, in_b);

`ifdef LOGIC_PIPE_FLAGS_EN
    assign entry = {^result, ~|result, result};
`else
    assign entry = result;
`endif

    // ready_v[i] is slot i's readiness; the extra top entry is the consumer's ready.
    logic [STAGES:0]   ready_v;
    logic [STAGES-1:0] valid_v;
    logic [DW-1:0]     data_v [STAGES];

    assign ready_v[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic          prev_valid;
        logic [DW-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = entry;
        end else begin : g_body
            assign prev_valid = valid_v[i-1];
            assign prev_data  = data_v[i-1];
        end

        logic_pipe_slot #(
            .W(DW)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .next_ready (ready_v[i+1]),
            .valid      (valid_v[i]),
            .data       (data_v[i]),
            .ready      (ready_v[i])
        );
    end

    assign in_ready  = ready_v[0];
    assign out_valid = valid_v[STAGES-1];
    assign out_y     = data_v[STAGES-1][WIDTH-1:0];

`ifdef LOGIC_PIPE_FLAGS_EN
    assign out_zero = data_v[STAGES-1][WIDTH];
    assign out_par  = data_v[STAGES-1][WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed op table, backpressure, bubble collapse,
// mid-flight reset, STAGES=1 latency, flags (when LOGIC_PIPE_FLAGS_EN) and a short random scoreboard run.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_y;
    logic        v3, r3, ov3, ordy3;
    logic        v1, r1, ov1, ordy1;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, y3, y1;
`ifdef LOGIC_PIPE_FLAGS_EN
    logic        out_zero, out_par, z3, p3, z1, p1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
`ifdef LOGIC_PIPE_FLAGS_EN
        , .out_zero(out_zero), .out_par(out_par)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(v3), .in_ready(r3), .in_op(op8),
        .in_a(a8), .in_b(b8), .out_valid(ov3), .out_ready(ordy3), .out_y(y3)
`ifdef LOGIC_PIPE_FLAGS_EN
        , .out_zero(z3), .out_par(p3)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(r1), .in_op(op8),
        .in_a(a8), .in_b(b8), .out_valid(ov1), .out_ready(ordy1), .out_y(y1)
`ifdef LOGIC_PIPE_FLAGS_EN
        , .out_zero(z1), .out_par(p1)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] held_y;
        logic [31:0] exp_y;
        logic        hold;
        int          pushed;
        int          popped;

        vecs[0] = '{3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[1] = '{3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        vecs[2] = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[3] = '{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F};
        vecs[4] = '{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF};
        vecs[5] = '{3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F};
        vecs[6] = '{3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0};
        vecs[7] = '{3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0};

        reset_n = 1'b0;
        apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
        out_ready = 1'b1;
        v3 = 1'b0; ordy3 = 1'b1; v1 = 1'b0; ordy1 = 1'b1;
        op8 = 3'd0; a8 = 8'h00; b8 = 8'h00;
        step();
        step();
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_out_y", out_y, 32'd0);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;

        $display("[TB] op table, back-to-back");
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                apply_stimulus(1'b1, vecs[c].op, vecs[c].a, vecs[c].b);
                #1;
                check_output($sformatf("tbl_in_ready_%0d", c), {31'b0, in_ready}, 32'd1);
            end else begin
                apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
            end
            step();
            if (c == 0) begin
                check_output("tbl_latency_empty", {31'b0, out_valid}, 32'd0);
            end else begin
                check_output($sformatf("tbl_valid_%0d", c - 1), {31'b0, out_valid}, 32'd1);
                check_output($sformatf("tbl_y_op%0d", c - 1), out_y, vecs[c-1].y);
            end
        end
        step();
        check_output("tbl_drained", {31'b0, out_valid}, 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        apply_stimulus(1'b1, vecs[0].op, vecs[0].a, vecs[0].b);
        step();
        check_output("bp_ready_after1", {31'b0, in_ready}, 32'd1);
        apply_stimulus(1'b1, vecs[1].op, vecs[1].a, vecs[1].b);
        step();
        check_output("bp_ready_full", {31'b0, in_ready}, 32'd0);
        check_output("bp_head_y", out_y, vecs[0].y);
        apply_stimulus(1'b1, 3'd7, 32'hDEAD_BEEF, 32'h0);
        step();
        step();
        check_output("bp_hold_y", out_y, vecs[0].y);
        check_output("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check_output("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        apply_stimulus(1'b1, vecs[2].op, vecs[2].a, vecs[2].b);
        out_ready = 1'b1;
        #1;
        check_output("bp_ready_on_pop", {31'b0, in_ready}, 32'd1);
        step();
        apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
        check_output("bp_second_y", out_y, vecs[1].y);
        step();
        check_output("bp_third_y", out_y, vecs[2].y);
        step();
        check_output("bp_empty", {31'b0, out_valid}, 32'd0);

        $display("[TB] bubble collapse, STAGES=3");
        ordy3 = 1'b0;
        v3 = 1'b1; op8 = 3'd3; a8 = 8'h00; b8 = 8'h00;
        step();
        check_output("bc_ready_1", {31'b0, r3}, 32'd1);
        op8 = 3'd0; a8 = 8'h3C; b8 = 8'h0F;
        step();
        check_output("bc_ready_2", {31'b0, r3}, 32'd1);
        op8 = 3'd2; a8 = 8'hA5; b8 = 8'hFF;
        step();
        check_output("bc_ready_full", {31'b0, r3}, 32'd0);
        check_output("bc_valid", {31'b0, ov3}, 32'd1);
        check_output("bc_y0", {24'b0, y3}, 32'h0000_00FF);
        v3 = 1'b0;
        ordy3 = 1'b1;
        step();
        check_output("bc_y1", {24'b0, y3}, 32'h0000_000C);
        step();
        check_output("bc_y2", {24'b0, y3}, 32'h0000_005A);
        step();
        check_output("bc_empty", {31'b0, ov3}, 32'd0);

        $display("[TB] STAGES=1 latency");
        v1 = 1'b1; op8 = 3'd3; a8 = 8'h00; b8 = 8'h00;
        step();
        check_output("s1_valid", {31'b0, ov1}, 32'd1);
        check_output("s1_nor", {24'b0, y1}, 32'h0000_00FF);
        ordy1 = 1'b0; op8 = 3'd1; a8 = 8'h12; b8 = 8'h40;
        #1;
        check_output("s1_full_ready", {31'b0, r1}, 32'd0);
        step();
        check_output("s1_hold", {24'b0, y1}, 32'h0000_00FF);
        v1 = 1'b0; ordy1 = 1'b1;
        step();
        check_output("s1_empty", {31'b0, ov1}, 32'd0);

        $display("[TB] reset mid-flight");
        out_ready = 1'b1;
        apply_stimulus(1'b1, vecs[3].op, vecs[3].a, vecs[3].b);
        step();
        apply_stimulus(1'b1, vecs[4].op, vecs[4].a, vecs[4].b);
        step();
        apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
        reset_n = 1'b0;
        step();
        check_output("mr_valid", {31'b0, out_valid}, 32'd0);
        check_output("mr_y", out_y, 32'd0);
        check_output("mr_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_output($sformatf("mr_no_stale_%0d", c), {31'b0, out_valid}, 32'd0);
        end

`ifdef LOGIC_PIPE_FLAGS_EN
        $display("[TB] flags");
        apply_stimulus(1'b1, 3'd2, 32'h1234_5678, 32'h1234_5678);
        step();
        apply_stimulus(1'b1, 3'd1, 32'h1, 32'h0);
        step();
        check_output("fl_xor_y", out_y, 32'd0);
        check_output("fl_xor_zero", {31'b0, out_zero}, 32'd1);
        check_output("fl_xor_par", {31'b0, out_par}, 32'd0);
        apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
        step();
        check_output("fl_or_zero", {31'b0, out_zero}, 32'd0);
        check_output("fl_or_par", {31'b0, out_par}, 32'd1);
        step();
`endif

        $display("[TB] random traffic");
        pushed = 0;
        popped = 0;
        hold   = 1'b0;
        held_y = 32'h0;
        for (int c = 0; c < 600; c++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            if (hold) begin
                check_output("rnd_hold_valid", {31'b0, out_valid}, 32'd1);
                check_output("rnd_hold_y", out_y, held_y);
            end
            hold   = out_valid && !out_ready;
            held_y = out_y;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(in_op, in_a, in_b));
                pushed++;
            end
            if (out_valid && out_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    check_output("rnd_unexpected_beat", out_y, 32'hxxxx_xxxx);
                end else begin
                    exp_y = exp_q.pop_front();
                    check_output("rnd_y", out_y, exp_y);
`ifdef LOGIC_PIPE_FLAGS_EN
                    check_output("rnd_zero", {31'b0, out_zero}, {31'b0, ~|exp_y});
                    check_output("rnd_par", {31'b0, out_par}, {31'b0, ^exp_y});
`endif
                end
            end
            step();
        end
        apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                popped++;
                if (exp_q.size() != 0) begin
                    exp_y = exp_q.pop_front();
                    check_output("rnd_drain_y", out_y, exp_y);
                end
            end
            step();
        end
        check_output("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("rnd_count", 32'(popped), 32'(pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
